// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: single-cycle MULT/MULTU, 32-step restoring DIV/DIVU
// with a sign-fixup cycle, plus MTHI/MTLO writes and the Decode stall hook.
module mult_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wdata,
    input  logic        hilo_use_d,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        md_stall
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t      state_q, state_d;
    logic        sgn_q, sgn_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        done_q, done_d;

    logic        a_neg, b_neg, in_a_neg;
    logic [31:0] b_mag, in_a_mag;
    logic [63:0] ax, bx, prod;
    logic [32:0] rem_sh, diff;
    logic [31:0] q_fix, r_fix;

    assign a_neg    = sgn_q & a_q[31];
    assign b_neg    = sgn_q & b_q[31];
    assign b_mag    = b_neg ? (32'd0 - b_q) : b_q;
    assign in_a_neg = ~op[0] & src_a[31];
    assign in_a_mag = in_a_neg ? (32'd0 - src_a) : src_a;

    // Sign/zero extension to 64 bits makes one modular multiply serve both MULT and MULTU.
    assign ax   = {{32{a_neg}}, a_q};
    assign bx   = {{32{b_neg}}, b_q};
    assign prod = ax * bx;

    // Restoring step: the quotient register shifts the dividend out as quotient bits shift in.
    assign rem_sh = {rem_q, quo_q[31]};
    assign diff   = rem_sh - {1'b0, b_mag};
    assign q_fix  = (a_neg ^ b_neg) ? (32'd0 - quo_q) : quo_q;
    assign r_fix  = a_neg ? (32'd0 - rem_q) : rem_q;

    always_comb begin
        state_d = state_q;
        sgn_d   = sgn_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        if (cancel) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sgn_d = ~op[0];
                        a_d   = src_a;
                        b_d   = src_b;
                        if (op[1]) begin
                            state_d = DIV;
                            cnt_d   = 5'd31;
                            rem_d   = 32'd0;
                            quo_d   = in_a_mag;
                        end else begin
                            state_d = MUL;
                        end
                    end else begin
                        if (wr_hi) hi_d = wdata;
                        if (wr_lo) lo_d = wdata;
                    end
                end
                MUL: begin
                    {hi_d, lo_d} = prod;
                    done_d       = 1'b1;
                    state_d      = IDLE;
                end
                DIV: begin
                    if (!diff[32]) begin
                        rem_d = diff[31:0];
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = rem_sh[31:0];
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd0) begin
                        cnt_d   = 5'd0;
                        state_d = FIX;
                    end
                end
                FIX: begin
                    if (b_q == 32'd0) begin
                        lo_d = 32'hFFFF_FFFF;
                        hi_d = a_q;
                    end else begin
                        lo_d = q_fix;
                        hi_d = r_fix;
                    end
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sgn_q   <= 1'b0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            cnt_q   <= 5'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sgn_q   <= sgn_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    // Gated by rst_n so a stale state before the first reset edge cannot stall the pipe.
    assign md_stall = busy & hilo_use_d & rst_n;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed expected results.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        rst_n, start, cancel, wr_hi, wr_lo, hilo_use_d;
    logic [1:0]  op;
    logic [31:0] src_a, src_b, wdata;
    logic [31:0] hi, lo;
    logic        busy, done, md_stall;

    int n_tests = 0;
    int n_fail  = 0;

    mult_div_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .cancel(cancel), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata), .hilo_use_d(hilo_use_d),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .md_stall(md_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; src_a = a; src_b = b; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Counts busy cycles after an accepted divide, then checks the result and done pulse.
    task automatic div_run(input string tag, input logic [31:0] elo, input logic [31:0] ehi);
        int n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
        chk({tag, "_cycles"}, 64'(n), 64'd33);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_lo"}, 64'(lo), 64'(elo));
        chk({tag, "_hi"}, 64'(hi), 64'(ehi));
        step();
        chk({tag, "_done_clr"}, 64'(done), 64'd0);
    endtask

    initial begin
        int n, stall_bad, done_seen;
        rst_n = 1'b0; start = 1'b0; cancel = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        hilo_use_d = 1'b1; op = 2'b00; src_a = '0; src_b = '0; wdata = '0;
        step();
        chk("rst_md_stall", 64'(md_stall), 64'd0);
        step();
        chk("rst_state", {hi, lo}, 64'd0);
        chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
        rst_n = 1'b1; hilo_use_d = 1'b0;
        step();

        // MULT -2 * 3
        accept(2'b00, 32'hFFFF_FFFE, 32'd3);
        chk("mult_busy", 64'(busy), 64'd1);
        step();
        chk("mult_busy_end", 64'(busy), 64'd0);
        chk("mult_done", 64'(done), 64'd1);
        chk("mult_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        step();
        chk("mult_done_clr", 64'(done), 64'd0);

        // MULTU max * max
        accept(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        chk("multu_res", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        accept(2'b11, 32'd100, 32'd7);
        div_run("divu_100_7", 32'd14, 32'd2);
        accept(2'b10, 32'hFFFF_FFF9, 32'd2);
        div_run("div_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        accept(2'b10, 32'd100, 32'hFFFF_FFF9);
        div_run("div_100_m7", 32'hFFFF_FFF2, 32'd2);
        accept(2'b10, 32'hFFFF_FFF9, 32'd0);
        div_run("div_by0", 32'hFFFF_FFFF, 32'hFFFF_FFF9);
        accept(2'b11, 32'h1234_5678, 32'd0);
        div_run("divu_by0", 32'hFFFF_FFFF, 32'h1234_5678);
        accept(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        div_run("div_ovf", 32'h8000_0000, 32'd0);

        // Stall during divide, start ignored while busy
        hilo_use_d = 1'b1;
        accept(2'b11, 32'd1000, 32'd9);
        n = 0; stall_bad = 0;
        while (busy && n < 100) begin
            if (md_stall !== 1'b1) stall_bad++;
            if (n == 9) begin
                op = 2'b01; src_a = 32'd5; src_b = 32'd5; start = 1'b1;
            end else start = 1'b0;
            n++;
            step();
        end
        start = 1'b0;
        chk("stall_all_busy", 64'(stall_bad), 64'd0);
        chk("stall_cycles", 64'(n), 64'd33);
        chk("stall_done_cycle", 64'(md_stall), 64'd0);
        chk("stall_res", {hi, lo}, {32'd1, 32'd111});
        hilo_use_d = 1'b0;
        step();

        // MTHI/MTLO, then cancel mid-divide with a blocked write
        wr_hi = 1'b1; wdata = 32'hA5A5_A5A5;
        step();
        wr_hi = 1'b0;
        chk("mthi", 64'(hi), 64'hA5A5_A5A5);
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h0000_1234;
        step();
        wr_lo = 1'b0; wdata = 32'h0000_5678; wr_lo = 1'b1; wr_hi = 1'b0;
        step();
        wr_lo = 1'b0;
        chk("mt_both", {hi, lo}, {32'h1234, 32'h5678});
        accept(2'b10, 32'd77, 32'd5);
        wr_hi = 1'b1; wdata = 32'hDEAD_BEEF;
        step();
        wr_hi = 1'b0;
        step(); step(); step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("cancel_busy", 64'(busy), 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_seen++;
            step();
        end
        chk("cancel_no_done", 64'(done_seen), 64'd0);
        chk("cancel_hilo", {hi, lo}, {32'h1234, 32'h5678});

        // cancel with start discards the start
        cancel = 1'b1;
        accept(2'b00, 32'd4, 32'd4);
        cancel = 1'b0;
        chk("cancel_start", 64'(busy), 64'd0);

        // start wins over wr_lo
        wr_lo = 1'b1; wdata = 32'hCAFE_0000;
        accept(2'b01, 32'd2, 32'd3);
        wr_lo = 1'b0;
        step();
        chk("start_over_wr", {hi, lo}, 64'd6);

        // reset mid-divide
        accept(2'b11, 32'd100, 32'd3);
        step(); step(); step();
        hilo_use_d = 1'b1;
        #1;
        chk("mid_busy_stall", 64'(md_stall), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_md_stall_comb", 64'(md_stall), 64'd0);
        step();
        chk("mid_rst_hilo", {hi, lo}, 64'd0);
        chk("mid_rst_flags", {61'd0, busy, done, md_stall}, 64'd0);
        rst_n = 1'b1; hilo_use_d = 1'b0;
        step();
        chk("post_rst_done", 64'(done), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL use these ports: clk  in  1  rising-edge clock.
REQ-002 The block SHALL use these ports: rst_n  in  1  reset; synchronous, active-low.
REQ-003 The block SHALL use these ports: start  in  1  accept request from Execute; sampled only in IDLE.
REQ-004 The block SHALL use these ports: op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 The block SHALL use these ports: src_a, src_b  in  32 each  rs/rt operands; src_a is the dividend and src_b the divisor.
REQ-006 The block SHALL use these ports: cancel  in  1  abort driven by the pipeline flush (Overflow/exception).
REQ-007 The block SHALL use these ports: wr_hi, wr_lo  in  1 each  MTHI/MTLO write enables.
REQ-008 The block SHALL use these ports: wdata  in  32  MTHI/MTLO data.
REQ-009 The block SHALL use these ports: hilo_use_d  in  1  Decode holds mfhi/mflo/mthi/mtlo/mult/div.
REQ-010 The block SHALL use these ports: hi, lo  out  32 each  architectural HI/LO registers.
REQ-011 The block SHALL use these ports: busy  out  1  state is not IDLE.
REQ-012 The block SHALL use these ports: done  out  1  one-cycle registered pulse after HI/LO update.
REQ-013 The block SHALL use these ports: md_stall  out  1  combinational busy AND hilo_use_d; ORed into stall_f/stall_d and flush_e by the hazard unit.

Function
REQ-014 The FSM SHALL have the states IDLE, MUL, DIV and FIX; busy SHALL be 1 in every state except IDLE.
REQ-015 In IDLE, start=1 with cancel=0 SHALL latch op, src_a and src_b at the edge; MULT/MULTU SHALL go to MUL and DIV/DIVU SHALL go to DIV with the iteration counter set to 31.
REQ-016 MUL SHALL last one cycle; at its closing edge {hi,lo} SHALL be the 64-bit product (signed for MULT, unsigned for MULTU), the FSM SHALL go to IDLE, and done SHALL assert for the next cycle.
REQ-017 DIV SHALL perform a restoring division on magnitudes for DIV and on raw values for DIVU, one quotient bit per cycle, for exactly 32 cycles (counter 31 down to 0), then go to FIX.
REQ-018 FIX SHALL last one cycle and apply signs for DIV: quotient negated when sign(a) XOR sign(b), remainder negated when sign(a); at its closing edge lo SHALL be the quotient and hi the remainder, the FSM SHALL go to IDLE, and done SHALL assert for the next cycle.
REQ-019 Division latency SHALL be 33 busy cycles (32 DIV + 1 FIX), with HI/LO valid in the 34th cycle after the accept edge.
REQ-020 Divide by zero (src_b=0) SHALL take the normal latency and produce lo=0xFFFFFFFF and hi=src_a for both DIV and DIVU.
REQ-021 DIV of 0x80000000 by 0xFFFFFFFF SHALL produce lo=0x80000000 and hi=0 with no trap.
REQ-022 start while busy SHALL be ignored.
REQ-023 wr_hi/wr_lo while busy SHALL be ignored.
REQ-024 In IDLE, wr_hi SHALL load hi from wdata and wr_lo SHALL load lo from wdata at the edge; both asserted SHALL load both registers.
REQ-025 In IDLE, start together with wr_hi/wr_lo SHALL take start; the write SHALL be dropped.
REQ-026 cancel=1 in any state SHALL force IDLE at the next edge, leave hi/lo unchanged and suppress done; cancel together with start SHALL discard the start.
REQ-027 All arithmetic SHALL use only 32-bit datapaths and a 33-bit partial remainder; there SHALL be no 64-bit combinational divider.

Reset
REQ-028 While rst_n=0 at a rising edge, the block SHALL set state=IDLE, hi=0, lo=0, busy=0, done=0 and counter=0.
REQ-029 Reset asserted mid-operation SHALL abort the operation with no HI/LO update and no done.
REQ-030 md_stall SHALL be 0 throughout reset.

Verification
REQ-031 Scenario: MULT with a=0xFFFFFFFE (-2), b=3 -> busy for 1 cycle, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulse.
REQ-032 Scenario: DIVU with a=100, b=7 -> busy for 33 cycles, then lo=14, hi=2, done exactly 34 cycles after the accept edge.
REQ-033 Scenario: DIV with a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); a second DIV with b=0 -> lo=0xFFFFFFFF, hi=src_a.
REQ-034 Scenario: hilo_use_d=1 during a DIV -> md_stall=1 for all 33 busy cycles and 0 in the done cycle; a new start issued at cycle 10 is ignored and the result is unchanged.
REQ-035 Scenario: cancel at cycle 5 of a DIV -> busy=0 at the next cycle, hi/lo hold their prior values (e.g. 0x1234/0x5678), no done.
REQ-036 Scenario: IDLE with wr_hi=1, wdata=0xA5A5A5A5 -> hi=0xA5A5A5A5; wr_lo in the same cycle as start -> lo unchanged; rst_n=0 mid-DIV -> all outputs 0 next cycle.
